// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin burst arbiter for 4 requesters with a one-cycle turnaround gap.
// Optional starvation monitor is built only when STARVE_MON_EN is defined.
module wrr_burst_arbiter #(
  parameter int WW           = 4,
  parameter int SW           = 6,
  parameter int STARVE_LIMIT = 40
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [3:0]      i_req,
  input  logic [4*WW-1:0] i_weights,
  output logic [3:0]      o_grant,
  output logic [1:0]      o_grant_id,
  output logic            o_busy,
  output logic            o_last,
  output logic [3:0]      o_starve
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_ptr, w_ptr_nxt;
  logic [WW-1:0] r_credit, w_credit_nxt;
  logic [3:0]    r_grant, w_grant_nxt;
  logic [1:0]    r_grant_id, w_grant_id_nxt;
  logic [3:0]    w_starve_req;
  logic          w_win_vld;
  logic [1:0]    w_win_id;
  logic [WW-1:0] w_win_weight;
  logic [WW-1:0] w_win_load;
  logic          w_release;

  // Scan from the far end so the requester nearest to r_ptr is the last to overwrite.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (i_req[r_ptr + 2'(k)]) begin
        w_win_vld = 1'b1;
        w_win_id  = r_ptr + 2'(k);
      end
    end
    for (int k = 3; k >= 0; k--) begin
      if (w_starve_req[k]) w_win_id = 2'(k);
    end
    if (!i_en) w_win_vld = 1'b0;
  end

  assign w_win_weight = i_weights[WW*w_win_id +: WW];
  assign w_win_load   = (w_win_weight == '0) ? WW'(1) : w_win_weight;
  assign w_release    = (r_credit == WW'(1)) || !i_req[r_grant_id] || !i_en;

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_credit_nxt   = r_credit;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    case (r_state)
      S_IDLE, S_GAP: begin
        w_grant_nxt = 4'b0000;
        if (w_win_vld) begin
          w_grant_nxt    = 4'b0001 << w_win_id;
          w_grant_id_nxt = w_win_id;
          w_credit_nxt   = w_win_load;
          w_state_nxt    = S_GRANT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_grant_nxt  = 4'b0000;
          w_ptr_nxt    = r_grant_id + 2'd1;
          w_credit_nxt = '0;
          w_state_nxt  = S_GAP;
        end else begin
          w_credit_nxt = r_credit - WW'(1);
        end
      end
      default: begin
        w_grant_nxt = 4'b0000;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd0;
      r_credit   <= '0;
      r_grant    <= 4'b0000;
      r_grant_id <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_credit   <= w_credit_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
    end
  end

`ifdef STARVE_MON_EN
  logic [SW-1:0] r_wait [4];
  logic [3:0]    w_starve;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < 4; i++) r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!i_req[i] || (w_grant_nxt[i] && !r_grant[i])) begin
          r_wait[i] <= '0;
        end else if (!r_grant[i] && (r_wait[i] != '1)) begin
          r_wait[i] <= r_wait[i] + SW'(1);
        end
      end
    end
  end

  always_comb begin
    w_starve = 4'b0000;
    for (int i = 0; i < 4; i++) w_starve[i] = (r_wait[i] >= SW'(STARVE_LIMIT));
  end

  // A requester that dropped its request this cycle must not win on a stale flag.
  assign w_starve_req = w_starve & i_req;
  assign o_starve     = w_starve;
`else
  assign w_starve_req = 4'b0000;
  assign o_starve     = 4'b0000;
`endif

  assign o_grant    = r_grant;
  assign o_grant_id = r_grant_id;
  assign o_busy     = |r_grant;
  assign o_last     = (|r_grant) && (r_credit == WW'(1));

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Self-checking bench for wrr_burst_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_wrr_burst_arbiter;

  localparam int WW  = 4;
  localparam int SW  = 6;
  localparam int LIM = 5;
`ifdef STARVE_MON_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clk, rst, en;
  logic [3:0]  req;
  logic [15:0] weights;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        busy, last;
  logic [3:0]  starve;

  int n_pass = 0;
  int n_total = 0;

  // model state: owner -1 means no grant this cycle
  int m_owner, m_rem, m_gid, m_ptr;
  int m_wait [4];

  wrr_burst_arbiter #(.WW(WW), .SW(SW), .STARVE_LIMIT(LIM)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req), .i_weights(weights),
    .o_grant(grant), .o_grant_id(grant_id), .o_busy(busy), .o_last(last),
    .o_starve(starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1; m_rem = 0; m_gid = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) m_wait[i] = 0;
  endtask

  function automatic int pick();
    if (!en) return -1;
    if (STARVE_ON)
      for (int i = 0; i < 4; i++) if (req[i] && m_wait[i] >= LIM) return i;
    for (int k = 0; k < 4; k++) if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  task automatic model_edge();
    int prev, issued, win, wt;
    prev = m_owner; issued = -1;
    win = pick();
    if (m_owner >= 0) begin
      if (m_rem == 1 || !req[m_owner] || !en) begin
        m_ptr = (m_owner + 1) % 4;
        m_owner = -1;
      end else m_rem--;
    end else if (win >= 0) begin
      wt = (weights >> (4 * win)) & 15;
      m_owner = win; m_rem = (wt == 0) ? 1 : wt; m_gid = win; issued = win;
    end
    if (STARVE_ON)
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || issued == i) m_wait[i] = 0;
        else if (prev != i && m_wait[i] < (1 << SW) - 1) m_wait[i]++;
      end
  endtask

  task automatic check_all();
    logic [3:0] es;
    es = 4'b0000;
    if (STARVE_ON) for (int i = 0; i < 4; i++) es[i] = (m_wait[i] >= LIM);
    chk("grant", 32'(grant), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("last", 32'(last), 32'(m_owner >= 0 && m_rem == 1));
    chk("starve", 32'(starve), 32'(es));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Called at posedge+1; asserts reset mid-cycle and releases it one cycle later.
  task automatic do_reset();
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  int exp_seq [15] = '{1, 1, 1, 1, 0, 2, 2, 2, 0, 4, 4, 0, 8, 0, 1};

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000; weights = 16'h0000;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    chk("reset_id", 32'(grant_id), 32'd0);

    // burst rotation
    weights = 16'h1234; en = 1'b1; req = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      step();
      chk("rot_seq", 32'(grant), 32'(exp_seq[c]));
    end
    for (int c = 0; c < 10; c++) step();

    // single requester
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 8; c++) step();

    // early release
    do_reset();
    req = 4'b0011;
    step(); step();
    req = 4'b0010;
    for (int c = 0; c < 7; c++) step();

    // zero weight
    do_reset();
    weights = 16'h1230; req = 4'b0001;
    for (int c = 0; c < 6; c++) step();

    // en drop mid-burst
    do_reset();
    weights = 16'h1234; req = 4'b1111;
    step(); step();
    en = 1'b0;
    for (int c = 0; c < 4; c++) step();
    en = 1'b1;
    for (int c = 0; c < 4; c++) step();

    // async reset mid-burst, then requester 0 first
    step();
    do_reset();
    req = 4'b1111;
    step();
    chk("post_rst_first", 32'(grant), 32'h1);

    // starvation
    do_reset();
    weights = 16'hFFFF; req = 4'b1111;
    for (int c = 0; c < 5; c++) step();
    chk("starve_at5", 32'(starve), STARVE_ON ? 32'he : 32'h0);
    for (int c = 0; c < 30; c++) step();

    // randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) weights = 16'($urandom);
      if ($urandom_range(0, 149) == 0) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
- Weighted round-robin arbiter that shares one resource among 4 requesters.
- Each grant is held for a programmable burst of up to 2^WW-1 cycles, then rotates to the next requester.
- A fixed one-cycle turnaround gap separates consecutive grants.
- Sits in front of the shared resource. It replaces the plain priority/round-robin arbiter wherever requesters need multi-cycle ownership.

Parameters:
- WW, 4, width of each per-requester weight field.
- SW, 6, width of each starvation wait counter (used only with STARVE_MON_EN).
- STARVE_LIMIT, 40, wait-cycle threshold that flags a requester as starved (used only with STARVE_MON_EN).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  arbitration enable. Low means no new grant and any active grant is released.
- req  in  4  request vector; bit i = requester i.
- weights  in  4*WW  burst length per requester; requester i occupies bits [WW*i+WW-1 : WW*i].
- grant  out  4  one-hot grant, registered.
- grant_id  out  2  index of the current/last grantee, registered.
- busy  out  1  high while any grant bit is high.
- last  out  1  high during the final cycle of a burst (current credit == 1).
- starve  out  4  starvation flags (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous, takes effect with no clock edge):
  - grant=0, grant_id=0, busy=0, last=0, starve=0.
  - Rotation pointer ptr=0, credit=0, state IDLE.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If en=1 and |req, the winner is the first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
  - The next edge sets grant[i], grant_id=i, credit=weights field i (a weight of 0 loads 1), and moves to GRANT.
  - Latency: req sampled at edge k gives grant visible after edge k.
- GRANT:
  - Each edge with req[i]=1 and en=1 decrements credit.
  - The grant is released (grant=0, state GAP, ptr=(i+1) mod 4) at the edge on which any of these holds:
    - credit==1;
    - req[i]=0;
    - en=0.
  - Consequence: with req[i] held continuously and weight W, grant[i] is high for exactly W consecutive cycles.
  - Simultaneous release causes produce one release; ptr still advances once.
- GAP:
  - Exactly one cycle with grant=0.
  - Arbitration runs in GAP using the updated ptr. A winner moves to GRANT at the next edge; no winner moves to IDLE.
  - A lone requester is therefore regranted after a single gap cycle.
- Weights are sampled only when a grant is issued; changes during a burst have no effect until the next grant.
- req bits of non-granted requesters have no effect during GRANT.
- grant_id holds its value through GAP/IDLE; busy = |grant; last = busy & (credit==1).
- Reset during GRANT or GAP aborts immediately. ptr returns to 0, so requester 0 has first priority after reset.

Optional Feature:
- Macro: STARVE_MON_EN.
- Enabled:
  - Per-requester SW-bit saturating counter wait[i] increments each cycle req[i]=1 and grant[i]=0.
  - wait[i] clears when grant[i] is issued or req[i]=0.
  - starve[i] = (wait[i] >= STARVE_LIMIT).
  - At arbitration, if any starve bit is set, the lowest-index starving requester wins, overriding ptr.
  - ptr is then updated from that winner as normal.
- Disabled:
  - No counters are built; starve is driven to 4'b0000.
  - Arbitration uses ptr only.

Test Plan:
- Burst rotation: reset, weights=16'h1234 (w0=4, w1=3, w2=2, w3=1), en=1, req=4'b1111 held. Required grant sequence:
  - 0001 for 4 cycles, gap;
  - 0010 for 3 cycles, gap;
  - 0100 for 2 cycles, gap;
  - 1000 for 1 cycle, gap;
  - then 0001 again.
  - last is high on the final cycle of each burst.
- Single requester, weights=16'h1234, ptr=0, req=4'b0100: grant=0100 the cycle after req, held 2 cycles, 1 gap cycle, then 0100 again; grant_id=2 throughout.
- Early release: req=4'b0011, weights=16'h1234. req[0] drops after 2 granted cycles → grant 0001 ends at the next edge, 1 gap cycle, then grant=0010 for 3 cycles; ptr=1 after the first release.
- Zero weight and en:
  - weights field 0 = 0 with req=4'b0001 → 1-cycle grants separated by 1-cycle gaps.
  - en=0 mid-burst → grant=0 at the next edge; no new grant while en=0.
- Async reset: assert rst=0 mid-burst between clock edges → grant=0, busy=0, last=0 immediately. After release with req=4'b1111, the first grant is 0001.
- STARVE_MON_EN, STARVE_LIMIT=5: weights all 15, req=4'b1111.
  - starve[1..3] rises once each wait count reaches 5.
  - At the next arbitration the winner is requester 1, not the ptr choice.
  - Without the macro, starve stays 0000.
